// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch / load-store requesters, the arbiter and the unified memory.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface mem_arbiter_if #(
    parameter int ADDR_W = 16
);
    logic              i_p0_req;
    logic [ADDR_W-1:0] i_p0_addr;
    logic              o_p0_gnt;
    logic              o_p0_rvalid;
    logic [31:0]       o_p0_rdata;
    logic              o_p0_err;

    logic              i_p1_req;
    logic [ADDR_W-1:0] i_p1_addr;
    logic [31:0]       i_p1_wdata;
    logic [3:0]        i_p1_mask;
    logic              i_p1_wren;
    logic              i_p1_lock;
    logic              o_p1_gnt;
    logic              o_p1_rvalid;
    logic [31:0]       o_p1_rdata;
    logic              o_p1_err;

    logic              o_lock_timeout;

    logic [ADDR_W-1:0] o_mem_addr;
    logic [31:0]       o_mem_wdata;
    logic [3:0]        o_mem_mask;
    logic              o_mem_wren;
    logic [31:0]       i_mem_rdata;

    modport slave (
        input  i_p0_req, i_p0_addr,
        output o_p0_gnt, o_p0_rvalid, o_p0_rdata, o_p0_err,
        input  i_p1_req, i_p1_addr, i_p1_wdata, i_p1_mask, i_p1_wren, i_p1_lock,
        output o_p1_gnt, o_p1_rvalid, o_p1_rdata, o_p1_err,
        output o_lock_timeout,
        output o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren,
        input  i_mem_rdata
    );

    modport master (
        output i_p0_req, i_p0_addr,
        input  o_p0_gnt, o_p0_rvalid, o_p0_rdata, o_p0_err,
        output i_p1_req, i_p1_addr, i_p1_wdata, i_p1_mask, i_p1_wren, i_p1_lock,
        input  o_p1_gnt, o_p1_rvalid, o_p1_rdata, o_p1_err,
        input  o_lock_timeout,
        input  o_mem_addr, o_mem_wdata, o_mem_mask, o_mem_wren,
        output i_mem_rdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the unified memory port between fetch (port 0) and load/store
// (port 1), with a port-1 bus lock that is force-released after LOCK_MAX locked cycles.
module mem_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int MEM_BYTES = 32768,
    parameter int LOCK_MAX  = 16
) (
    input  logic         i_clk,
    input  logic         i_reset,
    mem_arbiter_if.slave bus
);

    localparam int                CNT_W     = $clog2(LOCK_MAX + 1);
    localparam logic [ADDR_W:0]   MEM_LIMIT = (ADDR_W + 1)'(MEM_BYTES);
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(LOCK_MAX - 1);

    // Address of the highest enabled byte, one bit wider than the bus so it cannot wrap.
    function automatic logic [ADDR_W:0] top_byte(input logic [ADDR_W-1:0] addr,
                                                 input logic [3:0]        mask);
        logic [1:0] hi;
        hi = mask[3] ? 2'd3 : mask[2] ? 2'd2 : mask[1] ? 2'd1 : 2'd0;
        return {1'b0, addr} + {{(ADDR_W-1){1'b0}}, hi};
    endfunction

    logic             req0, req1;
    logic             gnt0, gnt1;
    logic             p0_oor, p1_oor;

    logic             last_gnt_q, last_gnt_d;
    logic             lock_q, lock_d;
    logic [CNT_W-1:0] lock_cnt_q, lock_cnt_d;
    logic             lock_to_q, lock_to_d;
    logic             p0_rvalid_q, p0_rvalid_d;
    logic [31:0]      p0_rdata_q, p0_rdata_d;
    logic             p0_err_q, p0_err_d;
    logic             p1_rvalid_q, p1_rvalid_d;
    logic [31:0]      p1_rdata_q, p1_rdata_d;
    logic             p1_err_q, p1_err_d;

    assign req0   = bus.i_p0_req & i_reset;
    assign req1   = bus.i_p1_req & i_reset;
    assign p0_oor = top_byte(bus.i_p0_addr, 4'hF) >= MEM_LIMIT;
    assign p1_oor = (|bus.i_p1_mask) && (top_byte(bus.i_p1_addr, bus.i_p1_mask) >= MEM_LIMIT);

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (lock_q) begin
            gnt1 = req1;
        end else if (req0 && req1) begin
            gnt0 = last_gnt_q;
            gnt1 = ~last_gnt_q;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

    always_comb begin
        bus.o_mem_addr  = '0;
        bus.o_mem_wdata = '0;
        bus.o_mem_mask  = '0;
        bus.o_mem_wren  = 1'b0;
        if (gnt0) begin
            bus.o_mem_addr = bus.i_p0_addr;
            bus.o_mem_mask = p0_oor ? 4'h0 : 4'hF;
        end else if (gnt1) begin
            bus.o_mem_addr  = bus.i_p1_addr;
            bus.o_mem_wdata = bus.i_p1_wdata;
            bus.o_mem_mask  = p1_oor ? 4'h0 : bus.i_p1_mask;
            bus.o_mem_wren  = bus.i_p1_wren & ~p1_oor;
        end
    end

    always_comb begin
        last_gnt_d  = last_gnt_q;
        lock_d      = lock_q;
        lock_cnt_d  = lock_q ? lock_cnt_q + CNT_W'(1) : '0;
        lock_to_d   = 1'b0;
        p0_rvalid_d = gnt0;
        p0_rdata_d  = p0_rdata_q;
        p0_err_d    = p0_err_q;
        p1_rvalid_d = gnt1;
        p1_rdata_d  = p1_rdata_q;
        p1_err_d    = p1_err_q;
        if (gnt0) begin
            last_gnt_d = 1'b0;
            p0_err_d   = p0_oor;
            p0_rdata_d = p0_oor ? '0 : bus.i_mem_rdata;
        end
        if (gnt1) begin
            last_gnt_d = 1'b1;
            lock_d     = bus.i_p1_lock;
            p1_err_d   = p1_oor;
            p1_rdata_d = (p1_oor || bus.i_p1_wren) ? '0 : bus.i_mem_rdata;
        end
        // Forced release overrides a same-cycle relock and hands the next tie to port 0.
        if (lock_q && (lock_cnt_q == CNT_LAST)) begin
            lock_d     = 1'b0;
            lock_cnt_d = '0;
            last_gnt_d = 1'b1;
            lock_to_d  = 1'b1;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            last_gnt_q  <= 1'b1;
            lock_q      <= 1'b0;
            lock_cnt_q  <= '0;
            lock_to_q   <= 1'b0;
            p0_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p0_err_q    <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p1_rdata_q  <= '0;
            p1_err_q    <= 1'b0;
        end else begin
            last_gnt_q  <= last_gnt_d;
            lock_q      <= lock_d;
            lock_cnt_q  <= lock_cnt_d;
            lock_to_q   <= lock_to_d;
            p0_rvalid_q <= p0_rvalid_d;
            p0_rdata_q  <= p0_rdata_d;
            p0_err_q    <= p0_err_d;
            p1_rvalid_q <= p1_rvalid_d;
            p1_rdata_q  <= p1_rdata_d;
            p1_err_q    <= p1_err_d;
        end
    end

    assign bus.o_p0_gnt       = gnt0;
    assign bus.o_p1_gnt       = gnt1;
    assign bus.o_p0_rvalid    = p0_rvalid_q;
    assign bus.o_p0_rdata     = p0_rdata_q;
    assign bus.o_p0_err       = p0_err_q;
    assign bus.o_p1_rvalid    = p1_rvalid_q;
    assign bus.o_p1_rdata     = p1_rdata_q;
    assign bus.o_p1_err       = p1_err_q;
    assign bus.o_lock_timeout = lock_to_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte memory model answers the memory port, expected responses
// go into per-port queues when a grant is expected and a negedge monitor pops and compares them.
module tb_mem_arbiter;

    logic clk;
    logic rst_n;
    int   cyc     = 0;
    int   n_chk   = 0;
    int   n_fail  = 0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t q0[$];
    exp_t q1[$];

    logic [7:0] mem [0:65535];

    localparam logic [31:0] W0  = 32'h0302_0100;
    localparam logic [31:0] W10 = 32'h1312_1110;

    mem_arbiter_if #(.ADDR_W(16)) bus ();

    mem_arbiter #(.ADDR_W(16), .MEM_BYTES(32768), .LOCK_MAX(16)) dut (
        .i_clk   (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    // Memory model: masked combinational read, masked write on the clock edge.
    always_comb begin
        bus.i_mem_rdata = '0;
        for (int k = 0; k < 4; k++)
            if (bus.o_mem_mask[k])
                bus.i_mem_rdata[8*k +: 8] = mem[16'(bus.o_mem_addr + 16'(k))];
    end

    always @(posedge clk) begin
        if (bus.o_mem_wren)
            for (int k = 0; k < 4; k++)
                if (bus.o_mem_mask[k])
                    mem[16'(bus.o_mem_addr + 16'(k))] = bus.o_mem_wdata[8*k +: 8];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (q0.size() > 0 && q0[0].due == cyc) begin
            e = q0.pop_front();
            check("p0_rvalid", 32'(bus.o_p0_rvalid), 32'd1);
            check("p0_rdata", bus.o_p0_rdata, e.rdata);
            check("p0_err", 32'(bus.o_p0_err), 32'(e.err));
        end else begin
            check("p0_idle_rvalid", 32'(bus.o_p0_rvalid), 32'd0);
        end
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e = q1.pop_front();
            check("p1_rvalid", 32'(bus.o_p1_rvalid), 32'd1);
            check("p1_rdata", bus.o_p1_rdata, e.rdata);
            check("p1_err", 32'(bus.o_p1_err), 32'(e.err));
        end else begin
            check("p1_idle_rvalid", 32'(bus.o_p1_rvalid), 32'd0);
        end
    end

    task automatic drive(input logic r0, input logic [15:0] a0, input logic r1,
                         input logic [15:0] a1, input logic [31:0] wd, input logic [3:0] m,
                         input logic we, input logic lk);
        bus.i_p0_req   = r0;
        bus.i_p0_addr  = a0;
        bus.i_p1_req   = r1;
        bus.i_p1_addr  = a1;
        bus.i_p1_wdata = wd;
        bus.i_p1_mask  = m;
        bus.i_p1_wren  = we;
        bus.i_p1_lock  = lk;
    endtask

    // Check grants and timeout for the current cycle, queue the expected responses, advance.
    task automatic step(input logic eg0, input logic eg1, input logic [31:0] ed0, input logic ee0,
                        input logic [31:0] ed1, input logic ee1, input logic eto);
        exp_t e;
        @(negedge clk);
        check("p0_gnt", 32'(bus.o_p0_gnt), 32'(eg0));
        check("p1_gnt", 32'(bus.o_p1_gnt), 32'(eg1));
        check("lock_timeout", 32'(bus.o_lock_timeout), 32'(eto));
        if (eg0) begin
            e.rdata = ed0; e.err = ee0; e.due = cyc + 1;
            q0.push_back(e);
        end
        if (eg1) begin
            e.rdata = ed1; e.err = ee1; e.due = cyc + 1;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i);
        rst_n = 1'b0;
        drive(1, 16'h0000, 1, 16'h0010, 32'h0, 4'hF, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_p0_gnt", 32'(bus.o_p0_gnt), 32'd0);
        check("rst_p1_gnt", 32'(bus.o_p1_gnt), 32'd0);
        check("rst_mem_mask", 32'(bus.o_mem_mask), 32'd0);
        check("rst_p0_rdata", bus.o_p0_rdata, 32'd0);
        check("rst_p1_err", 32'(bus.o_p1_err), 32'd0);
        check("rst_timeout", 32'(bus.o_lock_timeout), 32'd0);
        rst_n = 1'b1;

        // Alternating grants, first tie to port 0
        step(1, 0, W0, 0, 0, 0, 0);
        step(0, 1, 0, 0, W10, 0, 0);
        step(1, 0, W0, 0, 0, 0, 0);
        step(0, 1, 0, 0, W10, 0, 0);

        // Partial store then fetch of the same word
        drive(0, 16'h0000, 1, 16'h0100, 32'hA5A5_1234, 4'b0011, 1, 0);
        step(0, 1, 0, 0, 32'h0, 0, 0);
        drive(1, 16'h0100, 0, 16'h0000, 32'h0, 4'h0, 0, 0);
        step(1, 0, 32'h0302_1234, 0, 0, 0, 0);

        // Range boundary
        drive(0, 16'h0000, 1, 16'h7FFE, 32'h0, 4'hF, 0, 0);
        #2 check("oor_mem_mask", 32'(bus.o_mem_mask), 32'd0);
        step(0, 1, 0, 0, 32'h0, 1, 0);
        drive(0, 16'h0000, 1, 16'h7FFE, 32'h0, 4'b0011, 0, 0);
        step(0, 1, 0, 0, 32'h0000_FFFE, 0, 0);
        drive(0, 16'h0000, 1, 16'h7FFE, 32'h1122_3344, 4'hF, 1, 0);
        #2 check("oor_mem_wren", 32'(bus.o_mem_wren), 32'd0);
        step(0, 1, 0, 0, 32'h0, 1, 0);
        drive(0, 16'h0000, 1, 16'h7FFE, 32'h0, 4'b0011, 0, 0);
        step(0, 1, 0, 0, 32'h0000_FFFE, 0, 0);
        drive(1, 16'h7FFC, 0, 16'h0000, 32'h0, 4'h0, 0, 0);
        step(1, 0, 32'hFFFE_FDFC, 0, 0, 0, 0);
        drive(1, 16'h7FFD, 0, 16'h0000, 32'h0, 4'h0, 0, 0);
        step(1, 0, 32'h0, 1, 0, 0, 0);
        drive(0, 16'h0000, 1, 16'hFFFE, 32'h0, 4'hF, 0, 0);
        step(0, 1, 0, 0, 32'h0, 1, 0);

        // Lock, port 0 starved, unlocking store, then port 0 served
        drive(0, 16'h0000, 1, 16'h0010, 32'h0, 4'hF, 0, 1);
        step(0, 1, 0, 0, W10, 0, 0);
        drive(1, 16'h0000, 0, 16'h0000, 32'h0, 4'h0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        drive(1, 16'h0000, 1, 16'h0200, 32'hDEAD_BEEF, 4'hF, 1, 0);
        step(0, 1, 0, 0, 32'h0, 0, 0);
        drive(1, 16'h0000, 0, 16'h0000, 32'h0, 4'h0, 0, 0);
        step(1, 0, W0, 0, 0, 0, 0);
        drive(1, 16'h0200, 0, 16'h0000, 32'h0, 4'h0, 0, 0);
        step(1, 0, 32'hDEAD_BEEF, 0, 0, 0, 0);

        // Held lock: forced release after 16 locked cycles, port 0 wins next
        drive(1, 16'h0000, 1, 16'h0010, 32'h0, 4'hF, 0, 1);
        for (int t = 0; t < 20; t++) begin
            logic p0_turn;
            p0_turn = (t == 17);
            step(p0_turn, !p0_turn, W0, 0, W10, 0, p0_turn);
        end

        // Asynchronous reset mid-lock with a response pending
        #1 rst_n = 1'b0;
        q0.delete();
        q1.delete();
        #1;
        check("arst_p1_gnt", 32'(bus.o_p1_gnt), 32'd0);
        check("arst_p0_gnt", 32'(bus.o_p0_gnt), 32'd0);
        check("arst_p1_rvalid", 32'(bus.o_p1_rvalid), 32'd0);
        check("arst_p1_rdata", bus.o_p1_rdata, 32'd0);
        check("arst_p0_rdata", bus.o_p0_rdata, 32'd0);
        check("arst_mem_mask", 32'(bus.o_mem_mask), 32'd0);
        check("arst_mem_addr", 32'(bus.o_mem_addr), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("arst_hold_p1_gnt", 32'(bus.o_p1_gnt), 32'd0);
        drive(1, 16'h0000, 1, 16'h0010, 32'h0, 4'hF, 0, 0);
        rst_n = 1'b1;
        step(1, 0, W0, 0, 0, 0, 0);
        step(0, 1, 0, 0, W10, 0, 0);
        drive(0, 16'h0000, 0, 16'h0000, 32'h0, 4'h0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0);

        check("sb_p0_drained", 32'(q0.size()), 32'd0);
        check("sb_p1_drained", 32'(q1.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port arbiter placed in front of the byte-addressed unified memory (16-bit byte address, 32-bit data, 4-bit byte mask, combinational read, clocked write). It shares that single memory port between the instruction-fetch path (port 0, read-only) and the load/store path (port 1, read/write). Arbitration is round-robin, with a bus lock for read-modify-write sequences and a bounded lock timeout. Each granted access returns a registered response one cycle after the grant.

## Interface
- `ADDR_W`, default 16: byte address width.
- `MEM_BYTES`, default 32768: implemented memory size in bytes. Accesses beyond it are error responses.
- `LOCK_MAX`, default 16: maximum consecutive cycles port 1 may hold the lock.
- `i_clk`  in  1: clock. All state changes on the rising edge.
- `i_reset`  in  1: asynchronous, active-low reset.
- `i_p0_req`  in  1: fetch request; held until granted.
- `i_p0_addr`  in  ADDR_W: fetch byte address; a fetch always reads all 4 bytes.
- `o_p0_gnt`  out  1: port 0 granted this cycle (combinational).
- `o_p0_rvalid`  out  1: port 0 response valid.
- `o_p0_rdata`  out  32: port 0 read data.
- `o_p0_err`  out  1: port 0 response is an out-of-range error.
- `i_p1_req`  in  1: load/store request; held until granted.
- `i_p1_addr`  in  ADDR_W: load/store byte address.
- `i_p1_wdata`  in  32: store data.
- `i_p1_mask`  in  4: byte enables.
- `i_p1_wren`  in  1: 1 = store, 0 = load.
- `i_p1_lock`  in  1: request or keep the lock, sampled when port 1 is granted.
- `o_p1_gnt`, `o_p1_rvalid`, `o_p1_rdata[31:0]`, `o_p1_err`  out: same meaning as the port 0 signals, for port 1.
- `o_lock_timeout`  out  1: one-cycle pulse when the lock is force-released.
- `o_mem_addr`  out  ADDR_W: memory address.
- `o_mem_wdata`  out  32: memory write data.
- `o_mem_mask`  out  4: memory byte mask.
- `o_mem_wren`  out  1: memory write enable.
- `i_mem_rdata`  in  32: memory read data, combinational from `o_mem_addr`/`o_mem_mask`.

## Operation
**Registered state**
- `last_gnt` (1 bit).
- `lock_q` (1 bit).
- `lock_cnt` (width = clog2(LOCK_MAX+1)).
- Response registers for each port: rvalid, rdata, err.

**Grant, combinational**
- If `lock_q`=1: port 0 is never granted; port 1 is granted whenever it requests.
- Otherwise, if only one port requests, that port is granted.
- Otherwise, if both request, grant the port not equal to `last_gnt`.
- `o_p0_gnt` and `o_p1_gnt` are never both 1.
- On every grant, `last_gnt` is updated to the granted port.

**Memory drive, combinational**
- Port 0 granted: addr = `i_p0_addr`, mask = 4'hF, wren = 0, wdata = 0.
- Port 1 granted: the port 1 fields are passed through.
- No grant: addr = 0, mask = 0, wren = 0, wdata = 0.

**Range check**
- An access is out of range if any enabled byte address is ≥ MEM_BYTES, i.e. addr + (highest set mask bit index) ≥ MEM_BYTES.
- The check is performed in ADDR_W+1 bits so there is no wrap.
- An out-of-range access is still granted, but the memory drive forces mask = 0 and wren = 0, so memory is untouched.

**Response, registered at the edge after a grant**
- rvalid = 1.
- err = out-of-range.
- rdata = `i_mem_rdata` for an in-range load or fetch; 0 for a store or an error.
- Ports without a grant: rvalid = 0; rdata and err hold their previous values.

**Lock**
- When port 1 is granted with `i_p1_lock`=1: `lock_q` ← 1.
- When port 1 is granted with `i_p1_lock`=0: `lock_q` ← 0.
- `lock_cnt` increments each cycle `lock_q`=1 and clears when `lock_q`=0.
- If `lock_cnt` reaches LOCK_MAX − 1 while `lock_q`=1: next edge `lock_q` ← 0, `last_gnt` ← 1 (port 0 wins the next tie), `o_lock_timeout` pulses for 1 cycle.
- If a grant with `i_p1_lock`=1 coincides with the timeout edge, the timeout wins.

## Timing
- Grant is same-cycle (0 latency). The response is 1 cycle after the grant; the memory write commits on that same edge.
- Sustained throughput: 1 access per cycle in total. With both ports requesting continuously and no lock, grants alternate every cycle.
- A requester drops its request in the cycle after seeing its grant (or presents a new request).
- Reset values (asynchronous on `i_reset`=0):
  - All rvalid, err, rdata = 0.
  - `o_lock_timeout` = 0.
  - `lock_q` = 0, `lock_cnt` = 0.
  - `last_gnt` = 1, so port 0 wins the first tie.
- While reset is asserted, grants and memory drive are 0 regardless of requests.
- Reset mid-lock or mid-response: the lock is released and the pending response is discarded with no rvalid.

## Test plan
1. Reset, then both ports request reads at 0x0000 / 0x0010 for 4 cycles -> grants alternate P0, P1, P0, P1; each rvalid occurs 1 cycle after its grant with the matching memory word.
2. P1 store wdata 0xA5A5_1234, mask 4'b0011, addr 0x0100; then P0 fetch at 0x0100 -> P1 rvalid with rdata 0; P0 rdata[15:0] = 0x1234 and bytes 2–3 unchanged.
3. P1 load addr 0x7FFE, mask 4'hF (MEM_BYTES = 32768) -> err = 1, rdata = 0, mem mask driven 0. Same address with mask 4'b0011 -> err = 0.
4. P1 locks (load with lock=1), then performs a store with lock=0 while P0 requests continuously -> P0 receives no grant until the cycle after the unlocking store, then P0 is granted.
5. P1 holds lock=1 with continuous requests for 20 cycles and P0 requests -> `o_lock_timeout` pulses after 16 locked cycles, and P0 is granted next.
6. Assert `i_reset`=0 asynchronously mid-lock with a response pending -> all outputs 0 immediately; after release, the first tie is granted to P0.
